// File: rtl/sar_search_if.sv
// sar_search_if -- comparator handshake between the SAR search engine and an
// external comparator.
//   trial        candidate value presented to the comparator
//   trial_valid  trial is stable and awaiting a comparison result
//   cmp_valid    cmp_lt is valid for the trial currently presented
//   cmp_lt       unknown value < trial (unsigned)
// Modports: master = search engine, slave = comparator.
interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] trial;
    logic             trial_valid;
    logic             cmp_valid;
    logic             cmp_lt;

    modport master (
        output trial,
        output trial_valid,
        input  cmp_valid,
        input  cmp_lt
    );

    modport slave (
        input  trial,
        input  trial_valid,
        output cmp_valid,
        output cmp_lt
    );
endinterface

// File: rtl/sar_search.sv
// sar_search -- successive-approximation binary search driven by an external
// comparator. Resolves one bit per accepted comparison, MSB first.
//   clk     single clock, rising edge
//   rst     synchronous, active-high reset
//   start   request a new search (sampled only in IDLE)
//   cmp     comparator handshake (trial/trial_valid out, cmp_valid/cmp_lt in)
//   busy    high in PROBE and DONE
//   done    one-cycle pulse when result is updated
//   result  last completed search value
//
// state | meaning
// IDLE  | waiting for start; trial and result hold their last values
// PROBE | trial presented, waiting for cmp_valid to resolve bit idx
// DONE  | one-cycle completion pulse, then back to IDLE
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    sar_search_if.master     cmp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TRIAL_FIRST = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            idx_q    <= IDX_MAX;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    trial_d = TRIAL_FIRST;
                    idx_d   = IDX_MAX;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (cmp.cmp_valid) begin
                    // Keep the bit under test only if unknown >= trial.
                    trial_d[idx_q] = ~cmp.cmp_lt;
                    if (idx_q != '0) begin
                        trial_d[idx_q - 1'b1] = 1'b1;
                        idx_d = idx_q - 1'b1;
                    end else begin
                        result_d = trial_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmp.trial       = trial_q;
    assign cmp.trial_valid = (state_q == PROBE);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign result          = result_q;
endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int unsigned  unk = 0;
    int           delay = 0;
    bit           rnd_valid = 1'b0;
    int           wcnt = 0;

    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 1'b0;

    logic [W-1:0] trials[$];

    sar_search_if #(.WIDTH(W)) cmp_if ();

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp    (cmp_if),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // External comparator: answer is always correct; timing is what varies.
    assign cmp_if.cmp_lt = (unk < 32'(cmp_if.trial));

    initial cmp_if.cmp_valid = 1'b0;

    always @(negedge clk) begin
        if (cmp_if.trial_valid === 1'b1) begin
            if (rnd_valid) begin
                cmp_if.cmp_valid = 1'($urandom_range(0, 1));
            end else if (wcnt == delay) begin
                cmp_if.cmp_valid = 1'b1;
                wcnt = 0;
            end else begin
                cmp_if.cmp_valid = 1'b0;
                wcnt++;
            end
        end else begin
            // Garbage outside PROBE must be ignored.
            cmp_if.cmp_valid = 1'($urandom_range(0, 1));
            wcnt = 0;
        end
    end

    // Behavioural model: a search for u presents, at step k, the top k bits of
    // u followed by a single 1; after W accepted answers the result is u.
    function automatic logic [W-1:0] exp_trial(input int unsigned u, input int k);
        int unsigned v;
        v = ((u >> (W - k)) << (W - k)) | (32'd1 << (W - 1 - k));
        return v[W-1:0];
    endfunction

    int           m_phase = 0;   // 0 idle, 1 searching, 2 completion cycle
    int           m_k = 0;
    int unsigned  m_unk = 0;
    logic [W-1:0] m_trial = '0;
    logic [W-1:0] m_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_k      = 0;
            m_trial  = '0;
            m_result = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_k     = 0;
                    m_unk   = unk;
                    m_trial = exp_trial(m_unk, 0);
                end
                1: if (cmp_if.cmp_valid) begin
                    if (m_k == W - 1) begin
                        m_trial  = m_unk[W-1:0];
                        m_result = m_unk[W-1:0];
                        m_phase  = 2;
                    end else begin
                        m_k++;
                        m_trial = exp_trial(m_unk, m_k);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [2*W+2:0] act, exp;
        if (chk_en) begin
            act = {busy, done, cmp_if.trial_valid, cmp_if.trial, result};
            exp = {m_phase != 0, m_phase == 2, m_phase == 1, m_trial, m_result};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_model t=%0t {busy,done,tv,trial,result}: got %b expected %b",
                         $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", int'(busy === 1'b0), 1);
    endtask

    // Runs one search from IDLE; latency counts the start cycle through the
    // done cycle inclusive.
    task automatic run_search(input int unsigned u, input int d, input bit rv, output int lat);
        bit got;
        wait_idle();
        unk       = u;
        delay     = d;
        rnd_valid = rv;
        trials.delete();
        start = 1'b1;
        lat   = 1;
        got   = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (cmp_if.trial_valid === 1'b1 &&
                (trials.size() == 0 || trials[$] != cmp_if.trial))
                trials.push_back(cmp_if.trial);
            if (done === 1'b1) got = 1'b1;
        end
        check("done_timeout", int'(got), 1);
    endtask

    task automatic check_trials(input string name, input int t0, input int t1,
                                input int t2, input int t3);
        int exp[4];
        exp = '{t0, t1, t2, t3};
        check({name, "_count"}, trials.size(), 4);
        for (int i = 0; i < 4 && i < trials.size(); i++)
            check($sformatf("%s_trial%0d", name, i), int'(trials[i]), exp[i]);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;
        int second_done;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_result", int'(result), 0);
        check("reset_trial", int'(cmp_if.trial), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_search(9, 0, 1'b0, lat);
        check_trials("u9", 8, 12, 10, 9);
        check("u9_latency", lat, 6);
        check("u9_result", int'(result), 9);

        run_search(0, 0, 1'b0, lat);
        check_trials("u0", 8, 4, 2, 1);
        check("u0_result", int'(result), 0);

        run_search(15, 0, 1'b0, lat);
        check_trials("u15", 8, 12, 14, 15);
        check("u15_result", int'(result), 15);

        run_search(5, 3, 1'b0, lat);
        check_trials("u5_slow", 8, 4, 6, 5);
        check("u5_slow_latency", lat, 18);
        check("u5_slow_result", int'(result), 5);

        // start held high: back-to-back searches, one done pulse each.
        wait_idle();
        unk = 11; delay = 0; rnd_valid = 1'b0;
        start = 1'b1;
        ndone = 0; first_done = 0; second_done = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = n; else second_done = n;
            end
            if (n == 12) start = 1'b0;
        end
        check("held_done_count", ndone, 2);
        check("held_first_done", first_done, 5);
        check("held_second_done", second_done, 11);
        check("held_result", int'(result), 11);

        // Abort during the second probe of a search for 6.
        wait_idle();
        unk = 6; delay = 0; rnd_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_second_trial", int'(cmp_if.trial), 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_trial_valid", int'(cmp_if.trial_valid), 0);
        check("abort_result", int'(result), 0);
        check("abort_trial", int'(cmp_if.trial), 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_after", int'(busy), 0);
        run_search(6, 0, 1'b0, lat);
        check("after_abort_result", int'(result), 6);

        for (int i = 0; i < 40; i++) begin
            int unsigned u;
            u = $urandom_range(0, (1 << W) - 1);
            run_search(u, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
            check($sformatf("rand%0d_result", i), int'(result), int'(u));
            // Idle gap with start low: everything must hold.
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width in bits; the legal range is 2..8.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request a new search; sampled only in IDLE.
REQ-005 trial  output  WIDTH  SHALL carry the current candidate value presented to the external comparator.
REQ-006 trial_valid  output  1  SHALL be high while trial is stable and awaiting a comparison result.
REQ-007 cmp_valid  input  1  SHALL indicate that cmp_lt is valid for the trial currently presented.
REQ-008 cmp_lt  input  1  SHALL be 1 when the unknown value is less than trial (unsigned), else 0.
REQ-009 busy  output  1  SHALL be high in PROBE and DONE.
REQ-010 done  output  1  SHALL be a one-cycle pulse when result becomes valid.
REQ-011 result  output  WIDTH  SHALL hold the last completed search value until the next completion or reset.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, PROBE and DONE.
REQ-013 The block SHALL keep an internal bit pointer, idx, ranging from WIDTH-1 down to 0.
REQ-014 IDLE with start=1 SHALL, at the next edge, load trial = 1 followed by WIDTH-1 zeros (4'b1000 for WIDTH=4), set idx = WIDTH-1 and enter PROBE.
REQ-015 IDLE with start=0 SHALL hold all registers unchanged.
REQ-016 In PROBE, trial_valid SHALL be 1; in IDLE and DONE it SHALL be 0.
REQ-017 In PROBE with cmp_valid=0, the block SHALL hold trial and idx unchanged (wait indefinitely).
REQ-018 In PROBE with cmp_valid=1 and cmp_lt=1, the block SHALL clear trial[idx]; with cmp_lt=0 it SHALL keep trial[idx]=1.
REQ-019 On the same edge as REQ-018, if idx>0 the block SHALL set trial[idx-1]=1, decrement idx and remain in PROBE.
REQ-020 On the same edge as REQ-018, if idx==0 the block SHALL load result with the resolved trial and enter DONE.
REQ-021 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 start SHALL be ignored in PROBE and DONE; no restart occurs mid-search.
REQ-023 cmp_valid SHALL be ignored outside PROBE.
REQ-024 With cmp_valid held high continuously, latency SHALL be WIDTH+2 cycles from the start sample edge to the done pulse: 1 load cycle, WIDTH probe cycles, 1 DONE cycle.
REQ-025 trial SHALL keep its final value in IDLE until the next start.
REQ-026 All arithmetic SHALL be unsigned, with no wrap-around; result SHALL always lie in 0..2^WIDTH-1.

Reset
REQ-027 rst=1 at any edge SHALL force state=IDLE, trial=0, idx=WIDTH-1, result=0, done=0, trial_valid=0, busy=0.
REQ-028 rst SHALL take priority over start and cmp_valid on the same edge.
REQ-029 rst asserted mid-search SHALL abort the search; the cycle after rst deasserts, the block SHALL be idle, and result SHALL NOT be updated by the aborted search.

Verification
REQ-030 WIDTH=4, unknown=9, comparator model responding every cycle, pulse start -> trial sequence 8,12,10,9; done pulses 6 cycles after the start edge; result=9.
REQ-031 Unknown=0 -> trials 8,4,2,1; cmp_lt=1 on every trial; result=0. Unknown=15 -> trials 8,12,14,15; cmp_lt=0 on every trial; result=15.
REQ-032 Unknown=5 with cmp_valid delayed 3 cycles per trial -> trial held stable throughout each wait; result=5; done pulses 18 cycles after start.
REQ-033 start held high for the whole search -> exactly one done pulse per search, and a new search begins on the first IDLE cycle after DONE.
REQ-034 rst asserted during the second probe of a search for unknown=6 -> all outputs at reset values the next cycle; result=0; a following search for unknown=6 returns 6.
